// File: rtl/cmp_pkg.sv
// Shared definitions for the streaming comparator: result encoding and
// the saturating-increment helper used by the statistics counters.
package cmp_pkg;

  // 2-bit result code carried through the output register.
  // CMP_NONE only appears after reset, before the first result.
  typedef logic [1:0] cmp_code_t;

  localparam cmp_code_t CMP_NONE = 2'b00;
  localparam cmp_code_t CMP_LT   = 2'b01;
  localparam cmp_code_t CMP_GT   = 2'b10;
  localparam cmp_code_t CMP_EQ   = 2'b11;

  // Widest counter the helper supports.
  localparam int unsigned SAT_MAX_W = 64;

  // Add one to value, but stop at the all-ones value of a width-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(
    input logic [SAT_MAX_W-1:0] value,
    input int unsigned          width
  );
    logic [SAT_MAX_W-1:0] limit;
    if (width >= SAT_MAX_W) begin
      limit = {SAT_MAX_W{1'b1}};
    end else begin
      limit = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
    end
    if (value >= limit) begin
      sat_inc = limit;
    end else begin
      sat_inc = value + SAT_MAX_W'(1);
    end
  endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude compare of two WIDTH-bit operands, unsigned or
// two's-complement, with a symmetric equality tolerance band.
// The difference is taken on WIDTH+1 bits of extended operands, so the
// ordering never wraps. TOL is assumed to fit in WIDTH+1 bits.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TOL   = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output cmp_code_t        code,
  output logic             a_lt_b_order
);

  localparam logic [WIDTH:0] TOL_V = (WIDTH+1)'(TOL);

  logic [WIDTH:0] a_ext_s;
  logic [WIDTH:0] b_ext_s;
  logic [WIDTH:0] diff_s;
  logic [WIDTH:0] abs_diff_s;
  logic           in_band_s;

  // Extend, subtract, and classify the difference into lt / gt / eq.
  always_comb begin
    if (signed_mode) begin
      a_ext_s = {a[WIDTH-1], a};
      b_ext_s = {b[WIDTH-1], b};
    end else begin
      a_ext_s = {1'b0, a};
      b_ext_s = {1'b0, b};
    end

    diff_s = a_ext_s - b_ext_s;

    // |diff| is at most 2^WIDTH-1, so the negation cannot overflow.
    if (diff_s[WIDTH]) begin
      abs_diff_s = (~diff_s) + (WIDTH+1)'(1);
    end else begin
      abs_diff_s = diff_s;
    end

    in_band_s    = (abs_diff_s <= TOL_V);
    a_lt_b_order = diff_s[WIDTH];

    if (in_band_s) begin
      code = CMP_EQ;
    end else if (diff_s[WIDTH]) begin
      code = CMP_LT;
    end else begin
      code = CMP_GT;
    end
  end

endmodule

// File: rtl/cmp_stream_stats.sv
// Streaming comparator with a single-entry registered result behind a
// valid/ready handshake, plus saturating lt/gt/eq counters and the running
// min/max of operand A. Statistics follow accepted inputs, not consumed
// outputs, so a stalled result does not delay them.
module cmp_stream_stats
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TOL   = 0,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [WIDTH-1:0] min_a,
  output logic [WIDTH-1:0] max_a,
  output logic             seen
);

  // Result pipeline state
  logic             out_valid_q, out_valid_d;
  cmp_code_t        code_q, code_d;

  // Statistics state
  logic [CNT_W-1:0] cnt_lt_q, cnt_lt_d;
  logic [CNT_W-1:0] cnt_gt_q, cnt_gt_d;
  logic [CNT_W-1:0] cnt_eq_q, cnt_eq_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             seen_q, seen_d;

  // Handshake and comparator results
  logic             accept_s;
  logic             consume_s;
  cmp_code_t        ab_code_s;
  logic             ab_order_s;
  cmp_code_t        min_code_s;
  logic             a_lt_min_s;
  cmp_code_t        max_code_s;
  logic             max_lt_a_s;
  logic             unused_ok_s;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign consume_s = out_valid_q && out_ready;

  // A vs B: the reported result, with the tolerance band.
  cmp_core #(.WIDTH(WIDTH), .TOL(TOL)) u_cmp_ab (
    .a            (a),
    .b            (b),
    .signed_mode  (signed_mode),
    .code         (ab_code_s),
    .a_lt_b_order (ab_order_s)
  );

  // A vs running minimum, exact ordering in this transaction's mode.
  cmp_core #(.WIDTH(WIDTH), .TOL(0)) u_cmp_min (
    .a            (a),
    .b            (min_q),
    .signed_mode  (signed_mode),
    .code         (min_code_s),
    .a_lt_b_order (a_lt_min_s)
  );

  // Running maximum vs A; operands swapped so the order bit means max < A.
  cmp_core #(.WIDTH(WIDTH), .TOL(0)) u_cmp_max (
    .a            (max_q),
    .b            (a),
    .signed_mode  (signed_mode),
    .code         (max_code_s),
    .a_lt_b_order (max_lt_a_s)
  );

  // Only one output of each comparator instance is needed here.
  assign unused_ok_s = ^{ab_order_s, min_code_s, max_code_s};

  // Next state of the single-entry result register.
  always_comb begin
    out_valid_d = out_valid_q;
    code_d      = code_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      code_d      = ab_code_s;
    end else if (consume_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Result register; reset discards any in-flight result.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      out_valid_q <= 1'b0;
      code_q      <= CMP_NONE;
    end else begin
      out_valid_q <= out_valid_d;
      code_q      <= code_d;
    end
  end

  // Next state of the statistics; clr restarts them with the current accept as first sample.
  always_comb begin
    cnt_lt_d = cnt_lt_q;
    cnt_gt_d = cnt_gt_q;
    cnt_eq_d = cnt_eq_q;
    min_d    = min_q;
    max_d    = max_q;
    seen_d   = seen_q;

    if (clr) begin
      cnt_lt_d = {CNT_W{1'b0}};
      cnt_gt_d = {CNT_W{1'b0}};
      cnt_eq_d = {CNT_W{1'b0}};
      min_d    = {WIDTH{1'b0}};
      max_d    = {WIDTH{1'b0}};
      seen_d   = 1'b0;
      if (accept_s) begin
        case (ab_code_s)
          CMP_LT:  cnt_lt_d = CNT_W'(1);
          CMP_GT:  cnt_gt_d = CNT_W'(1);
          CMP_EQ:  cnt_eq_d = CNT_W'(1);
          default: cnt_eq_d = {CNT_W{1'b0}};
        endcase
        min_d  = a;
        max_d  = a;
        seen_d = 1'b1;
      end else begin
        seen_d = 1'b0;
      end
    end else if (accept_s) begin
      case (ab_code_s)
        CMP_LT:  cnt_lt_d = CNT_W'(sat_inc(SAT_MAX_W'(cnt_lt_q), CNT_W));
        CMP_GT:  cnt_gt_d = CNT_W'(sat_inc(SAT_MAX_W'(cnt_gt_q), CNT_W));
        CMP_EQ:  cnt_eq_d = CNT_W'(sat_inc(SAT_MAX_W'(cnt_eq_q), CNT_W));
        default: cnt_eq_d = cnt_eq_q;
      endcase
      if (!seen_q) begin
        min_d  = a;
        max_d  = a;
        seen_d = 1'b1;
      end else begin
        if (a_lt_min_s) begin
          min_d = a;
        end else begin
          min_d = min_q;
        end
        if (max_lt_a_s) begin
          max_d = a;
        end else begin
          max_d = max_q;
        end
      end
    end else begin
      seen_d = seen_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      cnt_lt_q <= {CNT_W{1'b0}};
      cnt_gt_q <= {CNT_W{1'b0}};
      cnt_eq_q <= {CNT_W{1'b0}};
      min_q    <= {WIDTH{1'b0}};
      max_q    <= {WIDTH{1'b0}};
      seen_q   <= 1'b0;
    end else begin
      cnt_lt_q <= cnt_lt_d;
      cnt_gt_q <= cnt_gt_d;
      cnt_eq_q <= cnt_eq_d;
      min_q    <= min_d;
      max_q    <= max_d;
      seen_q   <= seen_d;
    end
  end

  assign out_valid = out_valid_q;
  assign a_lt_b    = (code_q == CMP_LT);
  assign a_gt_b    = (code_q == CMP_GT);
  assign a_eq_b    = (code_q == CMP_EQ);
  assign cnt_lt    = cnt_lt_q;
  assign cnt_gt    = cnt_gt_q;
  assign cnt_eq    = cnt_eq_q;
  assign min_a     = min_q;
  assign max_a     = max_q;
  assign seen      = seen_q;

endmodule

// File: tb/tb_cmp_stream_stats.sv
// Bench for cmp_stream_stats. Two instances share one stimulus stream:
// d0 with exact compare and wide counters, d1 with TOL=2 and 2-bit counters.
// Expected results are pushed into per-instance queues on accept; a monitor
// pops and compares whenever a result is presented and consumed.
module tb_cmp_stream_stats;

  logic       CLK = 1'b0;
  logic       nRST, clr, in_valid, signed_mode, out_ready;
  logic [7:0] a, b;

  logic        d0_in_ready, d0_out_valid, d0_lt, d0_gt, d0_eq, d0_seen;
  logic [15:0] d0_cnt_lt, d0_cnt_gt, d0_cnt_eq;
  logic [7:0]  d0_min, d0_max;
  logic        d1_in_ready, d1_out_valid, d1_lt, d1_gt, d1_eq, d1_seen;
  logic [1:0]  d1_cnt_lt, d1_cnt_gt, d1_cnt_eq;
  logic [7:0]  d1_min, d1_max;

  always #5 CLK = ~CLK;

  cmp_stream_stats #(.WIDTH(8), .TOL(0), .CNT_W(16)) d0 (
    .CLK(CLK), .nRST(nRST), .clr(clr), .in_valid(in_valid), .in_ready(d0_in_ready),
    .signed_mode(signed_mode), .a(a), .b(b), .out_valid(d0_out_valid), .out_ready(out_ready),
    .a_lt_b(d0_lt), .a_gt_b(d0_gt), .a_eq_b(d0_eq),
    .cnt_lt(d0_cnt_lt), .cnt_gt(d0_cnt_gt), .cnt_eq(d0_cnt_eq),
    .min_a(d0_min), .max_a(d0_max), .seen(d0_seen)
  );

  cmp_stream_stats #(.WIDTH(8), .TOL(2), .CNT_W(2)) d1 (
    .CLK(CLK), .nRST(nRST), .clr(clr), .in_valid(in_valid), .in_ready(d1_in_ready),
    .signed_mode(signed_mode), .a(a), .b(b), .out_valid(d1_out_valid), .out_ready(out_ready),
    .a_lt_b(d1_lt), .a_gt_b(d1_gt), .a_eq_b(d1_eq),
    .cnt_lt(d1_cnt_lt), .cnt_gt(d1_cnt_gt), .cnt_eq(d1_cnt_eq),
    .min_a(d1_min), .max_a(d1_max), .seen(d1_seen)
  );

  // Reference model state. Flags encoded {lt,gt,eq}; counter index 0=lt 1=gt 2=eq.
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;
  bit         m_ov = 1'b0;
  bit [2:0]   m_flags [2];
  int         m_cnt [2][3];
  bit [7:0]   m_min, m_max;
  bit         m_seen;
  bit [2:0]   q0 [$];
  bit [2:0]   q1 [$];
  int         tols [2] = '{0, 2};
  int         cmax [2] = '{65535, 3};

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int val(input bit [7:0] x, input bit sm);
    if (sm) return int'($signed(x));
    return int'(x);
  endfunction

  function automatic bit [2:0] exp_res(input bit [7:0] x, input bit [7:0] y, input bit sm, input int tol);
    int d;
    d = val(x, sm) - val(y, sm);
    if (d <= tol && d >= -tol) return 3'b001;
    if (d < 0) return 3'b100;
    return 3'b010;
  endfunction

  function automatic int ridx(input bit [2:0] r);
    if (r == 3'b100) return 0;
    if (r == 3'b010) return 1;
    return 2;
  endfunction

  task automatic model_clear_stats();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++) m_cnt[k][i] = 0;
    m_min  = 8'h00;
    m_max  = 8'h00;
    m_seen = 1'b0;
  endtask

  task automatic check_state();
    chk("flags0", {d0_lt, d0_gt, d0_eq}, m_flags[0]);
    chk("cnt_lt0", d0_cnt_lt, m_cnt[0][0]);
    chk("cnt_gt0", d0_cnt_gt, m_cnt[0][1]);
    chk("cnt_eq0", d0_cnt_eq, m_cnt[0][2]);
    chk("min0", d0_min, m_min);
    chk("max0", d0_max, m_max);
    chk("seen0", d0_seen, m_seen);
    chk("flags1", {d1_lt, d1_gt, d1_eq}, m_flags[1]);
    chk("cnt_lt1", d1_cnt_lt, m_cnt[1][0]);
    chk("cnt_gt1", d1_cnt_gt, m_cnt[1][1]);
    chk("cnt_eq1", d1_cnt_eq, m_cnt[1][2]);
    chk("min1", d1_min, m_min);
    chk("max1", d1_max, m_max);
    chk("seen1", d1_seen, m_seen);
  endtask

  // One clock of stimulus; called at (posedge + 1) except for the very first call.
  task automatic cycle(input bit v, input bit sm, input bit [7:0] aa, input bit [7:0] bb,
                       input bit ordy, input bit c, input bit r);
    bit       acc;
    bit [2:0] e;
    in_valid = v; signed_mode = sm; a = aa; b = bb; out_ready = ordy; clr = c; nRST = r;
    #1;
    if (!r) begin
      chk("in_ready0", d0_in_ready, (!m_ov) || ordy);
      chk("in_ready1", d1_in_ready, (!m_ov) || ordy);
    end
    acc = v && ((!m_ov) || ordy) && !r;
    @(posedge CLK);
    if (r) begin
      m_ov = 1'b0;
      q0.delete();
      q1.delete();
      m_flags[0] = 3'b000;
      m_flags[1] = 3'b000;
      model_clear_stats();
      mon_en = 1'b1;
    end else begin
      if (acc) m_ov = 1'b1;
      else if (m_ov && ordy) m_ov = 1'b0;
      if (c) model_clear_stats();
      if (acc) begin
        for (int k = 0; k < 2; k++) begin
          e = exp_res(aa, bb, sm, tols[k]);
          m_flags[k] = e;
          if (k == 0) q0.push_back(e);
          else q1.push_back(e);
          if (m_cnt[k][ridx(e)] < cmax[k]) m_cnt[k][ridx(e)]++;
        end
        if (!m_seen) begin
          m_min = aa; m_max = aa; m_seen = 1'b1;
        end else begin
          if (val(aa, sm) < val(m_min, sm)) m_min = aa;
          if (val(aa, sm) > val(m_max, sm)) m_max = aa;
        end
      end
    end
    #1;
    check_state();
  endtask

  // Monitor: compare presented results against the queue heads, pop on consume.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("out_valid0", d0_out_valid, q0.size() != 0);
      if (d0_out_valid && q0.size() != 0) begin
        chk("result0", {d0_lt, d0_gt, d0_eq}, q0[0]);
        if (out_ready) void'(q0.pop_front());
      end
      chk("out_valid1", d1_out_valid, q1.size() != 0);
      if (d1_out_valid && q1.size() != 0) begin
        chk("result1", {d1_lt, d1_gt, d1_eq}, q1[0]);
        if (out_ready) void'(q1.pop_front());
      end
    end
  end

  initial begin
    bit [7:0] ra, rb;
    // Reset for two cycles
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    // Basic
    cycle(1'b1, 1'b0, 8'h0F, 8'h03, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    // Signed vs unsigned
    cycle(1'b1, 1'b0, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    // Tolerance edges
    cycle(1'b1, 1'b0, 8'd10, 8'd12, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'd10, 8'd13, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'd0,  8'd2,  1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hFE, 8'h01, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'd13, 8'd10, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    // Backpressure: three stalled cycles, then streaming
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i), 8'h21, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 8'h41, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    // Saturation and clr with a coinciding accept
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h07, 8'h07, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'd5, 8'd9, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    // Reset while a result is held
    cycle(1'b1, 1'b0, 8'h33, 8'h22, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h44, 8'h22, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    // Random traffic, biased towards near-equal operands
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) rb = 8'($urandom_range(0, 255));
      else rb = 8'(int'(ra) + int'($urandom_range(0, 6)) - 3);
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra, rb,
            $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
    end
    // Drain
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
